tilt_dir_filter: RTL and testbench
==================================

Name: tilt_dir_filter

Overview:
- Sits between the accelerometer read-back (spi_ee_config X/Y words) and the seven-segment/LED indicators.
- Averages raw 10-bit signed X/Y tilt samples over fixed windows and classifies each window average as one of five directions, using a dead zone with hysteresis.
- Debounces the classification: the output changes only after N consecutive agreeing windows.
- Drives a registered direction code and the active-low HEX pattern.

Parameters:
- AVG_LOG2, 3: window length is 2^AVG_LOG2 samples.
- DEAD_ZONE, 32: abs threshold for returning to CENTER.
- HYST, 8: extra margin required to leave CENTER. Threshold is DEAD_ZONE+HYST.
- STABLE_CNT, 4: consecutive agreeing windows required before oDIR changes. Legal range 1..15.

Ports:
- iCLK  in  1  system clock (MAX10_CLK1_50 domain).
- iRST  in  1  asynchronous, active-high reset (driven by reset_delay oRST).
- iVALID  in  1  one-cycle sample strobe, synchronous to iCLK. Upstream owns the CDC.
- iX  in  10  signed X sample.
- iY  in  10  signed Y sample.
- oAVG_X  out  10  signed window average of X.
- oAVG_Y  out  10  signed window average of Y.
- oAVG_VALID  out  1  one-cycle pulse when oAVG_X/oAVG_Y update.
- oDIR  out  3  debounced direction code.
- oDIR_CHG  out  1  one-cycle pulse when oDIR changes.
- oSEG  out  8  active-low pattern, bit order dp,g,f,e,d,c,b,a.

Behaviour:
- Reset (async, iRST=1):
  - Accumulators and sample count cleared to 0.
  - oAVG_X=oAVG_Y=0, oAVG_VALID=0, oDIR=CENTER, oDIR_CHG=0, oSEG=8'h80.
  - Candidate=CENTER, stable count=0.
  - A partial window in progress is discarded.
- Accumulate:
  - Each cycle with iVALID=1 adds the sign-extended sample to a signed (10+AVG_LOG2)-bit accumulator per axis and increments the sample count.
  - Back-to-back iVALID cycles are all counted as samples.
  - Cycles with iVALID=0 hold all state.
- Window close (cycle t, iVALID high on the final sample, count = 2^AVG_LOG2-1):
  - At edge t+1: oAVG = (acc + sample) >>> AVG_LOG2, arithmetic shift (floor toward -inf); oAVG_VALID=1 for one cycle.
  - Accumulators and count return to 0 on that same edge. A sample at t+1 starts the new window.
- Classification (combinational from oAVG, used when oAVG_VALID=1):
  - ax/ay = absolute value, 10-bit unsigned; -512 maps to 512.
  - If oDIR==CENTER: class is CENTER when max(ax,ay) < DEAD_ZONE+HYST.
  - Else: class is CENTER when ax < DEAD_ZONE and ay < DEAD_ZONE.
  - Otherwise, if ax >= ay (ties go to the X axis): X negative -> RIGHT, X non-negative -> LEFT.
  - Otherwise: Y negative -> UP, Y non-negative -> DOWN.
- Debounce (edge t+2, only when oAVG_VALID=1):
  - class == oDIR: stable count = 0.
  - class == candidate: count++.
  - Otherwise: candidate = class, count = 1.
  - When the resulting count equals STABLE_CNT: oDIR = candidate, oDIR_CHG=1 for one cycle, count = 0, and oSEG is updated on the same edge.
  - Net latency: final sample of the deciding window -> oDIR/oSEG change is 2 cycles.
- oSEG mapping: CENTER 8'h80, RIGHT 8'hF9, LEFT 8'hCF, UP 8'hDC, DOWN 8'hE3.
- oDIR_CHG is never asserted without an actual change in oDIR.

Decomposition:
- Package tilt_pkg:
  - Direction codes: CENTER=3'd0, LEFT=3'd1, RIGHT=3'd2, UP=3'd3, DOWN=3'd4.
  - The five SEG constants.
  - Function dir_to_seg.
- One sub-module, tilt_axis_avg: a per-axis accumulator/averager, instantiated twice and sharing the count and strobe from the parent.

Test Plan (default parameters):
- Reset: assert iRST mid-run -> oDIR=0, oSEG=8'h80, oAVG=0 immediately. Feed 5 samples, release reset, then feed 8 samples of x=+8 -> oAVG_VALID fires only after 8 post-reset samples, with oAVG_X=8.
- Direction change: 32 samples x=+100, y=0 -> oAVG_VALID pulses 4 times; oDIR=LEFT, oSEG=8'hCF, and oDIR_CHG pulses exactly once, 2 cycles after sample 32.
- Floor rounding and extremes:
  - 7 samples of 0 plus one x=-1 -> oAVG_X=-1.
  - 8 samples x=-512 -> oAVG_X=-512; after 4 windows oDIR=RIGHT, oSEG=8'hF9.
- Hysteresis:
  - From CENTER, 6 windows at x=+36 -> oDIR stays CENTER.
  - Then 4 windows at x=+40 -> LEFT.
  - Then 6 windows at x=+33 -> stays LEFT.
  - Then 4 windows at x=+31 -> CENTER.
- Interrupted candidate and tie:
  - Windows LEFT,LEFT,LEFT,UP,LEFT,LEFT,LEFT -> no oDIR_CHG.
  - Then 4 windows at x=-50, y=+50 -> RIGHT (tie goes to X).
  - Then 4 windows at y=-60 -> UP, oSEG=8'hDC.
- Continuous strobe: iVALID held high for 16 cycles -> oAVG_VALID on cycles 9 and 17 (counting from the first sample), with no sample lost.

Source files
------------

// File: rtl/tilt_pkg.sv
// rtl/tilt_pkg.sv - direction codes and seven-segment patterns for the tilt filter
package tilt_pkg;

    typedef enum logic [2:0] {
        DIR_CENTER = 3'd0,
        DIR_LEFT   = 3'd1,
        DIR_RIGHT  = 3'd2,
        DIR_UP     = 3'd3,
        DIR_DOWN   = 3'd4
    } dir_t;

    // Active-low, bit order dp,g,f,e,d,c,b,a
    localparam logic [7:0] SEG_CENTER = 8'h80;
    localparam logic [7:0] SEG_RIGHT  = 8'hF9;
    localparam logic [7:0] SEG_LEFT   = 8'hCF;
    localparam logic [7:0] SEG_UP     = 8'hDC;
    localparam logic [7:0] SEG_DOWN   = 8'hE3;

    function automatic logic [7:0] dir_to_seg(input dir_t d);
        case (d)
            DIR_LEFT:  return SEG_LEFT;
            DIR_RIGHT: return SEG_RIGHT;
            DIR_UP:    return SEG_UP;
            DIR_DOWN:  return SEG_DOWN;
            default:   return SEG_CENTER;
        endcase
    endfunction

endpackage

// File: rtl/tilt_axis_avg.sv
// rtl/tilt_axis_avg.sv - per-axis window accumulator with floor-rounded average
module tilt_axis_avg #(
    parameter int AVG_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       window_end,
    input  logic [9:0] sample,
    output logic [9:0] avg
);
    localparam int ACC_W = 10 + AVG_LOG2;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    assign sum = acc + {{AVG_LOG2{sample[9]}}, sample};

    // Dropping the low AVG_LOG2 bits of a two's-complement sum is an arithmetic shift (floor)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            avg <= '0;
        end else if (sample_en) begin
            if (window_end) begin
                acc <= '0;
                avg <= sum[ACC_W-1:AVG_LOG2];
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/tilt_dir_filter.sv
// rtl/tilt_dir_filter.sv - windowed tilt averaging, hysteretic classification and debounced direction
module tilt_dir_filter
    import tilt_pkg::*;
#(
    parameter int AVG_LOG2   = 3,
    parameter int DEAD_ZONE  = 32,
    parameter int HYST       = 8,
    parameter int STABLE_CNT = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iVALID,
    input  logic [9:0] iX,
    input  logic [9:0] iY,
    output logic [9:0] oAVG_X,
    output logic [9:0] oAVG_Y,
    output logic       oAVG_VALID,
    output logic [2:0] oDIR,
    output logic       oDIR_CHG,
    output logic [7:0] oSEG
);
    localparam logic [10:0] ENTER_TH = 11'(DEAD_ZONE + HYST);
    localparam logic [10:0] EXIT_TH  = 11'(DEAD_ZONE);

    logic [AVG_LOG2-1:0] sample_cnt;
    logic                window_end;
    logic [9:0]          ax, ay, axy_max;
    logic                is_center;
    dir_t                cls, dir, cand, cand_next;
    logic [3:0]          stable_cnt, cnt_next;

    assign window_end = &sample_cnt;

    tilt_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_x (
        .clk(iCLK), .rst(iRST), .sample_en(iVALID), .window_end(window_end),
        .sample(iX), .avg(oAVG_X)
    );

    tilt_axis_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_y (
        .clk(iCLK), .rst(iRST), .sample_en(iVALID), .window_end(window_end),
        .sample(iY), .avg(oAVG_Y)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sample_cnt <= '0;
            oAVG_VALID <= 1'b0;
        end else begin
            oAVG_VALID <= iVALID && window_end;
            if (iVALID)
                sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // -512 negates to 10'h200, which read as unsigned is the correct magnitude
    assign ax      = oAVG_X[9] ? (~oAVG_X + 10'd1) : oAVG_X;
    assign ay      = oAVG_Y[9] ? (~oAVG_Y + 10'd1) : oAVG_Y;
    assign axy_max = (ax >= ay) ? ax : ay;

    always_comb begin
        cls = DIR_CENTER;
        if (dir == DIR_CENTER)
            is_center = {1'b0, axy_max} < ENTER_TH;
        else
            is_center = ({1'b0, ax} < EXIT_TH) && ({1'b0, ay} < EXIT_TH);
        if (!is_center) begin
            if (ax >= ay)
                cls = oAVG_X[9] ? DIR_RIGHT : DIR_LEFT;
            else
                cls = oAVG_Y[9] ? DIR_UP : DIR_DOWN;
        end
    end

    always_comb begin
        cand_next = cand;
        cnt_next  = stable_cnt;
        if (cls == dir) begin
            cnt_next = 4'd0;
        end else if (cls == cand) begin
            cnt_next = stable_cnt + 4'd1;
        end else begin
            cand_next = cls;
            cnt_next  = 4'd1;
        end
    end

    // A change only fires on a class differing from dir, so oDIR_CHG always marks a real change
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            dir        <= DIR_CENTER;
            cand       <= DIR_CENTER;
            stable_cnt <= 4'd0;
            oDIR_CHG   <= 1'b0;
            oSEG       <= SEG_CENTER;
        end else begin
            oDIR_CHG <= 1'b0;
            if (oAVG_VALID) begin
                cand <= cand_next;
                if (cnt_next == 4'(STABLE_CNT)) begin
                    dir        <= cand_next;
                    oDIR_CHG   <= 1'b1;
                    stable_cnt <= 4'd0;
                    oSEG       <= dir_to_seg(cand_next);
                end else begin
                    stable_cnt <= cnt_next;
                end
            end
        end
    end

    assign oDIR = dir;

endmodule

// File: tb/tb_tilt_dir_filter.sv
// tb/tb_tilt_dir_filter.sv - self-checking bench for tilt_dir_filter
module tb_tilt_dir_filter;
    localparam int WIN       = 8;
    localparam int DZ        = 32;
    localparam int HY        = 8;
    localparam int STABLE    = 4;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iVALID = 1'b0;
    logic [9:0] iX = '0;
    logic [9:0] iY = '0;
    logic [9:0] oAVG_X, oAVG_Y;
    logic       oAVG_VALID;
    logic [2:0] oDIR;
    logic       oDIR_CHG;
    logic [7:0] oSEG;

    int checks = 0;
    int failures = 0;

    tilt_dir_filter dut (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .iX(iX), .iY(iY),
        .oAVG_X(oAVG_X), .oAVG_Y(oAVG_Y), .oAVG_VALID(oAVG_VALID),
        .oDIR(oDIR), .oDIR_CHG(oDIR_CHG), .oSEG(oSEG)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // 0 CENTER, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN
    function automatic int classify(input int x, input int y, input int cur);
        int a, b;
        a = iabs(x);
        b = iabs(y);
        if (cur == 0 && ((a > b) ? a : b) < DZ + HY) return 0;
        if (cur != 0 && a < DZ && b < DZ) return 0;
        if (a >= b) return (x < 0) ? 2 : 1;
        return (y < 0) ? 3 : 4;
    endfunction

    function automatic int seg_of(input int d);
        case (d)
            1: return 8'hCF;
            2: return 8'hF9;
            3: return 8'hDC;
            4: return 8'hE3;
            default: return 8'h80;
        endcase
    endfunction

    // Reference model: running sums per window and the debounce rules on window averages
    int m_sum_x, m_sum_y, m_n, m_avg_x, m_avg_y, m_dir, m_cand, m_cnt;
    bit m_avg_valid, m_chg;
    int t_c, t_nd, t_nc, t_n, t_sx, t_sy, t_k;
    bit t_ch;

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            m_sum_x <= 0; m_sum_y <= 0; m_n <= 0;
            m_avg_x <= 0; m_avg_y <= 0; m_avg_valid <= 0;
            m_dir <= 0; m_cand <= 0; m_cnt <= 0; m_chg <= 0;
        end else begin
            t_nd = m_dir; t_nc = m_cand; t_n = m_cnt; t_ch = 0;
            if (m_avg_valid) begin
                t_c = classify(m_avg_x, m_avg_y, m_dir);
                if (t_c == m_dir) t_n = 0;
                else if (t_c == m_cand) t_n = m_cnt + 1;
                else begin t_nc = t_c; t_n = 1; end
                if (t_n == STABLE) begin t_nd = t_nc; t_ch = 1; t_n = 0; end
            end
            m_dir <= t_nd; m_cand <= t_nc; m_cnt <= t_n; m_chg <= t_ch;
            if (iVALID) begin
                t_sx = m_sum_x + int'($signed(iX));
                t_sy = m_sum_y + int'($signed(iY));
                t_k  = m_n + 1;
                if (t_k == WIN) begin
                    m_avg_x <= floor_div(t_sx, WIN);
                    m_avg_y <= floor_div(t_sy, WIN);
                    m_avg_valid <= 1;
                    m_sum_x <= 0; m_sum_y <= 0; m_n <= 0;
                end else begin
                    m_sum_x <= t_sx; m_sum_y <= t_sy; m_n <= t_k;
                    m_avg_valid <= 0;
                end
            end else begin
                m_avg_valid <= 0;
            end
        end
    end

    int chg_pulses = 0;
    int avg_pulses = 0;

    always @(negedge iCLK) begin
        check("avg_valid", oAVG_VALID, m_avg_valid);
        check("avg_x", $signed(oAVG_X), m_avg_x);
        check("avg_y", $signed(oAVG_Y), m_avg_y);
        check("dir", oDIR, m_dir);
        check("dir_chg", oDIR_CHG, m_chg);
        check("seg", oSEG, seg_of(m_dir));
        if (oDIR_CHG) chg_pulses <= chg_pulses + 1;
        if (oAVG_VALID) avg_pulses <= avg_pulses + 1;
    end

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic send(input int x, input int y, input int gap);
        iVALID = 1'b1;
        iX = 10'(x);
        iY = 10'(y);
        step();
        iVALID = 1'b0;
        repeat (gap) step();
    endtask

    typedef struct {
        int x;
        int y;
        int nwin;
        int exp_dir;
        int exp_seg;
        int exp_chg;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int c0, a0, bx, by;
        tbl[0]  = '{100,    0, 4, 1, 8'hCF, 1};
        tbl[1]  = '{-512,   0, 4, 2, 8'hF9, 1};
        tbl[2]  = '{0,      0, 4, 0, 8'h80, 1};
        tbl[3]  = '{36,     0, 6, 0, 8'h80, 0};
        tbl[4]  = '{40,     0, 4, 1, 8'hCF, 1};
        tbl[5]  = '{33,     0, 6, 1, 8'hCF, 0};
        tbl[6]  = '{31,     0, 4, 0, 8'h80, 1};
        tbl[7]  = '{100,    0, 3, 0, 8'h80, 0};
        tbl[8]  = '{0,   -100, 1, 0, 8'h80, 0};
        tbl[9]  = '{100,    0, 3, 0, 8'h80, 0};
        tbl[10] = '{-50,   50, 4, 2, 8'hF9, 1};
        tbl[11] = '{0,    -60, 4, 3, 8'hDC, 1};
        tbl[12] = '{0,     60, 4, 4, 8'hE3, 1};

        repeat (3) step();
        iRST = 1'b0;
        step();
        check("reset_dir", oDIR, 0);
        check("reset_seg", oSEG, 8'h80);
        check("reset_avg_x", oAVG_X, 0);
        check("reset_avg_valid", oAVG_VALID, 0);

        // Floor rounding: seven zeros and one -1 average to -1
        for (int i = 0; i < 7; i++) send(0, 0, $urandom_range(0, 2));
        send(-1, 0, 0);
        check("floor_valid", oAVG_VALID, 1);
        check("floor_avg_x", $signed(oAVG_X), -1);
        repeat (3) step();

        for (int r = 0; r < 13; r++) begin
            c0 = chg_pulses;
            for (int w = 0; w < tbl[r].nwin; w++)
                for (int s = 0; s < WIN; s++)
                    send(tbl[r].x, tbl[r].y, $urandom_range(0, 2));
            repeat (3) step();
            check($sformatf("tbl%0d_dir", r), oDIR, tbl[r].exp_dir);
            check($sformatf("tbl%0d_seg", r), oSEG, tbl[r].exp_seg);
            check($sformatf("tbl%0d_avg_x", r), $signed(oAVG_X), tbl[r].x);
            check($sformatf("tbl%0d_chg_count", r), chg_pulses - c0, tbl[r].exp_chg);
        end

        // Mid-window reset, samples during reset, then a clean window
        for (int i = 0; i < 3; i++) send(200, 0, 1);
        iRST = 1'b1;
        #1;
        check("midrst_dir", oDIR, 0);
        check("midrst_seg", oSEG, 8'h80);
        check("midrst_avg_x", oAVG_X, 0);
        check("midrst_avg_y", oAVG_Y, 0);
        for (int i = 0; i < 5; i++) send(300, 0, 0);
        iRST = 1'b0;
        step();
        a0 = avg_pulses;
        for (int i = 0; i < 7; i++) send(8, 0, $urandom_range(0, 2));
        check("postrst_no_early_avg", avg_pulses - a0, 0);
        send(8, 0, 0);
        check("postrst_valid", oAVG_VALID, 1);
        check("postrst_avg_x", $signed(oAVG_X), 8);
        repeat (2) step();

        // Continuous strobe: 16 back-to-back samples x=1..16
        for (int c = 1; c <= 18; c++) begin
            if (c == 9) begin
                check("cont_valid_9", oAVG_VALID, 1);
                check("cont_avg_9", $signed(oAVG_X), 4);
            end else if (c == 17) begin
                check("cont_valid_17", oAVG_VALID, 1);
                check("cont_avg_17", $signed(oAVG_X), 12);
            end else begin
                check($sformatf("cont_idle_%0d", c), oAVG_VALID, 0);
            end
            iVALID = (c <= 16);
            iX = 10'(c);
            iY = 10'd0;
            step();
        end
        iVALID = 1'b0;
        repeat (2) step();

        // Random windows around random biases, checked cycle by cycle against the model
        for (int w = 0; w < 50; w++) begin
            bx = int'($urandom_range(0, 800)) - 400;
            by = int'($urandom_range(0, 800)) - 400;
            if ($urandom_range(0, 3) == 0) begin bx = bx / 10; by = by / 10; end
            for (int s = 0; s < WIN; s++)
                send(bx + int'($urandom_range(0, 100)) - 50,
                     by + int'($urandom_range(0, 100)) - 50,
                     $urandom_range(0, 2));
        end
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
